// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and shift-amount width helper for alu_multicycle.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL1 = 4'b0011;
  localparam logic [3:0] OP_SHL2 = 4'b0100;
  localparam logic [3:0] OP_SHR4 = 4'b0101;
  localparam logic [3:0] OP_INC  = 4'b0110;
  localparam logic [3:0] OP_SHLV = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bits of operand2 used as the variable shift amount.
  function automatic int shamt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: low DWIDTH bits of a*b, DWIDTH cycles after start.
// done pulses on the final iteration edge with product already valid; start restarts it at any time.
module alu_mul_iter #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              done,
  output logic [DWIDTH-1:0] product
);

  localparam int CW = $clog2(DWIDTH + 1);

  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] mcand;
  logic [DWIDTH-1:0] mplier;
  logic [DWIDTH-1:0] acc_nxt;
  logic [CW-1:0]     cnt;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  // product is the accumulator including the iteration happening on this edge
  assign product = acc_nxt;
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= CW'(DWIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: latency 1 for single-cycle ops, DWIDTH+1 for MUL (ALU_MULTICYCLE_MUL_EN);
// result held in DONE until out_ready, in_ready low while busy or while a result is stalled.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] operand1,
  input  logic [DWIDTH-1:0] operand2,
  input  logic [3:0]        operation,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out,
  output logic              Z,
  output logic              N,
  output logic              C
);

  localparam int SHW = shamt_w(DWIDTH);

  state_t            state;
  logic              live;
  logic              accept;
  logic              is_mul;
  logic [DWIDTH-1:0] res;
  logic              cy;
  logic [DWIDTH:0]   sum;

  // live keeps in_ready low through reset and until the first clock after release
  assign in_ready  = live && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

`ifdef ALU_MULTICYCLE_MUL_EN
  logic              mul_done;
  logic [DWIDTH-1:0] mul_prod;

  assign is_mul = (operation == OP_MUL);

  alu_mul_iter #(.DWIDTH(DWIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (operand1),
    .b       (operand2),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    res = '0;
    cy  = 1'b0;
    sum = '0;
    case (operation)
      OP_PASS: res = operand1;
      OP_ADD: begin
        sum = {1'b0, operand1} + {1'b0, operand2};
        res = sum[DWIDTH-1:0];
        cy  = sum[DWIDTH];
      end
      OP_SUB: begin
        // extended MSB of the difference is the unsigned borrow
        sum = {1'b0, operand1} - {1'b0, operand2};
        res = sum[DWIDTH-1:0];
        cy  = sum[DWIDTH];
      end
      OP_SHL1: begin
        res = operand1 << 1;
        cy  = operand1[DWIDTH-1];
      end
      OP_SHL2: res = operand1 << 2;
      OP_SHR4: res = operand1 >> 4;
      OP_INC: begin
        sum = {1'b0, operand1} + {{DWIDTH{1'b0}}, 1'b1};
        res = sum[DWIDTH-1:0];
        cy  = sum[DWIDTH];
      end
      OP_SHLV: res = operand1 << operand2[SHW-1:0];
      OP_AND:  res = operand1 & operand2;
      OP_OR:   res = operand1 | operand2;
      OP_XOR:  res = operand1 ^ operand2;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      live  <= 1'b0;
      out   <= '0;
      Z     <= 1'b0;
      N     <= 1'b0;
      C     <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept && is_mul) begin
            state <= ST_BUSY;
          end else if (accept) begin
            state <= ST_DONE;
            out   <= res;
            Z     <= (res == '0);
            N     <= res[DWIDTH-1];
            C     <= cy;
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
`ifdef ALU_MULTICYCLE_MUL_EN
          if (mul_done) begin
            state <= ST_DONE;
            out   <= mul_prod;
            Z     <= (mul_prod == '0);
            N     <= mul_prod[DWIDTH-1];
            C     <= 1'b0;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at DWIDTH=16; adapts to ALU_MULTICYCLE_MUL_EN.
module tb_alu_multicycle;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] operand1;
  logic [DW-1:0] operand2;
  logic [3:0]    operation;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic          Z, N, C;

  always #5 clk = ~clk;

  alu_multicycle #(.DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .Z         (Z),
    .N         (N),
    .C         (C)
  );

  typedef struct packed {
    logic [DW-1:0] res;
    logic          z;
    logic          n;
    logic          c;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result transfers on the edge following a negedge with valid and ready high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got out=%h Z=%b N=%b C=%b with nothing expected", out, Z, N, C);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result{out,Z,N,C}", {13'd0, out, Z, N, C}, {13'd0, e});
      end
    end
  end

  // Drive a request and wait (bounded) for its accepting edge; returns at edge+1.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] r, input logic z, input logic n, input logic c,
                       input bit push);
    bit got;
    got       = 1'b0;
    in_valid  = 1'b1;
    operation = op;
    operand1  = a;
    operand2  = b;
    if (push) sb.push_back('{res: r, z: z, n: n, c: c});
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: op=%b never accepted", op);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand1  = '0;
    operand2  = '0;
    operation = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_flags", {29'd0, Z, N, C}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Wrapping add, latency 1
    issue(4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("add_latency_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    issue(4'b0010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b1);

    // Multiply
`ifdef ALU_MULTICYCLE_MUL_EN
    issue(4'b1011, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_in_ready_c%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("mul_busy_out_valid_c%0d", i), {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    check("mul_out_valid_c17", {31'd0, out_valid}, 32'd1);
`else
    issue(4'b1011, 16'h0012, 16'h0034, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("mul_disabled_latency", {31'd0, out_valid}, 32'd1);
`endif
    @(posedge clk);
    #1;

    // Directed single-cycle vectors, issued back to back
    issue(4'b0000, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b0011, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(4'b0100, 16'h4003, 16'h0000, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b0101, 16'h8ABC, 16'h0000, 16'h08AB, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b0110, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(4'b1000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b1001, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'b1010, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'b0111, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b1111, 16'h0001, 16'h0013, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("op1111_latency", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    issue(4'b1100, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'b0001, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Stalled result with a pending request that must not be accepted
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'b0110, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    in_valid  = 1'b1;
    operation = 4'b1010;
    operand1  = 16'h00FF;
    operand2  = 16'h0F0F;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready_c%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("stall_hold_c%0d", i), {13'd0, out_valid, out, N, C}, {13'd0, 1'b1, 16'h8000, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    sb.push_back('{res: 16'h0FF0, z: 1'b0, n: 1'b0, c: 1'b0});
    @(negedge clk);
    check("same_edge_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("same_edge_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of work: nothing stale may come out afterwards
    @(posedge clk);
    #1 out_ready = 1'b0;
`ifdef ALU_MULTICYCLE_MUL_EN
    issue(4'b1011, 16'h0012, 16'h0034, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_before_reset", {31'd0, in_ready}, 32'd0);
`else
    issue(4'b0001, 16'h00FF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("stalled_before_reset", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'h0100});
`endif
    rst_n = 1'b0;
    #1;
    check("midop_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midop_rst_out", {16'd0, out}, 32'd0);
    check("midop_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midop_rst_flags", {29'd0, Z, N, C}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midop_in_ready_after_release", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid === 1'b1) stale = 1'b1;
    end
    check("no_stale_result", {31'd0, stale}, 32'd0);
    @(posedge clk);
    #1;
    issue(4'b0001, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);

    // Drain the scoreboard
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter DWIDTH, default 16, sets the operand and result width; legal range 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 operand1  input  DWIDTH  first operand.
REQ-007 operand2  input  DWIDTH  second operand.
REQ-008 operation  input  4  opcode.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out  output  DWIDTH  registered result.
REQ-012 Z / N / C  output  1 each  zero, negative (out MSB) and carry/borrow flags, registered with out.

Function
REQ-013 A request is accepted on a rising edge where in_valid and in_ready are both 1; operand1, operand2 and operation are captured on that edge.
REQ-014 FSM states are IDLE, BUSY and DONE; IDLE->DONE for single-cycle ops, IDLE->BUSY for MUL, BUSY->DONE after DWIDTH iterations, DONE->IDLE on out_ready with no new accept, DONE->DONE or DONE->BUSY on out_ready with a simultaneous accept.
REQ-015 in_ready = (state==IDLE) or (state==DONE and out_ready); in_ready is 0 in BUSY.
REQ-016 out_valid = (state==DONE); out, Z, N and C hold stable while out_valid=1 and out_ready=0.
REQ-017 Opcodes: 0000 pass op1; 0001 op1+op2; 0010 op1-op2; 0011 op1<<1; 0100 op1<<2; 0101 op1>>4 (logical); 0110 op1+1; 0111 op1<<op2[log2(DWIDTH)-1:0]; 1000 AND; 1001 OR; 1010 XOR; 1011 MUL (low DWIDTH bits of op1*op2).
REQ-018 Single-cycle ops give latency 1: out_valid is 1 in the cycle after the accepting edge.
REQ-019 MUL is an iterative shift-add that takes DWIDTH BUSY cycles, so out_valid rises DWIDTH+1 cycles after the accepting edge.
REQ-020 Arithmetic wraps modulo 2^DWIDTH.
REQ-021 C is the carry-out for add/inc, the borrow (op1<op2 unsigned) for sub, op1[DWIDTH-1] for opcode 0011, and 0 for all other opcodes.
REQ-022 Z = (out==0), computed from the result being registered in the same cycle, never from the previous out.
REQ-023 Opcodes 1100-1111 return out=0, Z=1, N=0, C=0 with latency 1.
REQ-024 in_valid asserted while in_ready=0 is ignored and has no side effects.

Reset
REQ-025 While rst_n=0: state=IDLE, out=0, Z=0, N=0, C=0, out_valid=0, in_ready=0, and any multiplier progress is discarded.
REQ-026 Reset mid-MUL aborts the operation; the first accept after rst_n deasserts starts from a clean IDLE, and in_ready is 1 on the first clock after deassertion.

Configuration
REQ-027 Macro ALU_MULTICYCLE_MUL_EN defined: opcode 1011 performs the iterative MUL and the BUSY state exists.
REQ-028 Macro ALU_MULTICYCLE_MUL_EN undefined: the multiplier is omitted, opcode 1011 behaves as an undefined opcode (REQ-023), and BUSY is unreachable.

Structure
REQ-029 Shared package alu_pkg holds the opcode localparams, the FSM state encoding and the DWIDTH shift-amount width helper.
REQ-030 The multiplier is a sub-module alu_mul_iter (start, done, DWIDTH parameter), instantiated only under ALU_MULTICYCLE_MUL_EN.

Verification
REQ-031 DWIDTH=16, ADD 0xFFFF+0x0001 with out_ready=1 -> next cycle out_valid=1, out=0x0000, Z=1, C=1, N=0.
REQ-032 SUB 0x0003-0x0005 -> out=0xFFFE, N=1, C=1, Z=0.
REQ-033 MUL 0x0012*0x0034 with macro defined -> in_ready=0 for 16 cycles, out_valid at cycle 17, out=0x03A8; with macro undefined -> out=0, Z=1 at cycle 1.
REQ-034 Back-to-back: opcode 0110 on 0x7FFF with out_ready=0 for 3 cycles -> out=0x8000 held, N=1, no second accept; out_ready=1 plus a new request -> accepted on the same edge.
REQ-035 rst_n pulled low at BUSY cycle 5 of a MUL -> out=0 and out_valid=0 immediately, in_ready=1 one cycle after release, no stale result appears.
REQ-036 Opcode 1111 and opcode 0111 with op2=0x0013 on op1=0x0001 -> 0x0000/Z=1 and 0x0008 respectively.
